// File: rtl/output_conditioner.sv
// Output conditioner: registered level output with a minimum hold time between transitions,
// a one-deep deferred request slot, and pulses for transitions and request collisions.
module output_conditioner #(
    parameter int counterwidth = 4,
    parameter int holdtime     = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic risereq,
    input  logic fallreq,
    output logic driven,
    output logic busy,
    output logic pending,
    output logic txedge,
    output logic collide
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [counterwidth-1:0] RELOAD = counterwidth'(holdtime - 1);

    state_t                  state_q, state_d;
    logic [counterwidth-1:0] count_q, count_d;
    logic                    driven_q, driven_d;
    logic                    pending_q, pending_d;
    logic                    pendlevel_q, pendlevel_d;
    logic                    txedge_q, txedge_d;
    logic                    collide_q, collide_d;

    logic req_valid;
    logic req_level;
    logic req_opposite;
    logic pend_eff;
    logic lvl_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            driven_q    <= 1'b0;
            pending_q   <= 1'b0;
            pendlevel_q <= 1'b0;
            txedge_q    <= 1'b0;
            collide_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            driven_q    <= driven_d;
            pending_q   <= pending_d;
            pendlevel_q <= pendlevel_d;
            txedge_q    <= txedge_d;
            collide_q   <= collide_d;
        end
    end

    // A collision is treated as "no request"; the hold counter keeps running.
    always_comb begin
        req_valid    = risereq ^ fallreq;
        req_level    = risereq;
        req_opposite = req_valid && (req_level != driven_q);

        state_d     = state_q;
        count_d     = count_q;
        driven_d    = driven_q;
        pending_d   = pending_q;
        pendlevel_d = pendlevel_q;
        txedge_d    = 1'b0;
        collide_d   = risereq & fallreq;
        pend_eff    = pending_q;
        lvl_eff     = pendlevel_q;

        case (state_q)
            IDLE: begin
                if (req_opposite) begin
                    driven_d = ~driven_q;
                    txedge_d = 1'b1;
                    state_d  = HOLD;
                    count_d  = RELOAD;
                end
            end
            HOLD: begin
                // Resolve this cycle's request against the slot before the expiry decision.
                if (req_opposite) begin
                    pend_eff = 1'b1;
                    lvl_eff  = req_level;
                end else if (req_valid && pending_q) begin
                    pend_eff = 1'b0;
                end

                if (count_q != '0) begin
                    count_d     = count_q - 1'b1;
                    pending_d   = pend_eff;
                    pendlevel_d = lvl_eff;
                end else if (pend_eff) begin
                    driven_d    = lvl_eff;
                    txedge_d    = 1'b1;
                    pending_d   = 1'b0;
                    pendlevel_d = lvl_eff;
                    count_d     = RELOAD;
                end else begin
                    pending_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        driven  = driven_q;
        busy    = (state_q == HOLD);
        pending = pending_q;
        txedge  = txedge_q;
        collide = collide_q;
    end

endmodule

// File: doc/output_conditioner.md
OUTPUT_CONDITIONER -- requirements
Module: output_conditioner

Interface
REQ-001 Parameter: counterwidth, default 4, hold counter width in bits.
REQ-002 Parameter: holdtime, default 5, minimum clock cycles the output is held constant after any transition; legal range 1 .. 2^counterwidth.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 risereq  input  1  one-cycle request to drive the output high.
REQ-006 fallreq  input  1  one-cycle request to drive the output low.
REQ-007 driven  output  1  conditioned output level, glitch-free and registered.
REQ-008 busy  output  1  high while the output is inside its hold window.
REQ-009 pending  output  1  high while one deferred request is stored.
REQ-010 txedge  output  1  one-cycle pulse, high in the cycle in which driven has just changed.
REQ-011 collide  output  1  one-cycle pulse flagging simultaneous risereq and fallreq.

Function
REQ-012 The block SHALL have two states: IDLE (busy=0) and HOLD (busy=1), plus a 1-deep pending register (pending, pendlevel).
REQ-013 A request SHALL be "opposite" when its level differs from driven, and "redundant" otherwise; a redundant request SHALL be ignored with no flag.
REQ-014 IDLE, opposite request at edge k: driven toggles at edge k, txedge=1 for the following cycle, the block enters HOLD, and the counter loads holdtime-1.
REQ-015 HOLD with counter>0: the counter SHALL decrement each edge, and driven SHALL remain constant.
REQ-016 HOLD, opposite request: the block SHALL store pending=1 and pendlevel=requested level, with no change to driven.
REQ-017 HOLD with pending=1 and a request equal to the current driven level: the block SHALL clear pending (cancellation), with no change to driven.
REQ-018 HOLD with pending=1 and a further request for the same level as pendlevel: the request SHALL be absorbed, with no further change.
REQ-019 HOLD with counter==0 at edge j: if pending=1 or an opposite request is present at edge j, driven SHALL toggle at edge j, txedge SHALL pulse, pending SHALL clear, and the counter SHALL reload holdtime-1 while the block stays in HOLD; otherwise the block SHALL return to IDLE.
REQ-020 At the counter==0 edge with both pending=1 and a new request, the new request SHALL be resolved first per REQ-013/016/017; the result SHALL then govern REQ-019.
REQ-021 risereq and fallreq both high in the same cycle: both SHALL be ignored, collide SHALL pulse for one cycle, and all other state SHALL be unchanged.
REQ-022 Consecutive driven transitions SHALL be separated by at least holdtime cycles under all input sequences.
REQ-023 busy SHALL be high for exactly holdtime cycles after an isolated transition.
REQ-024 The counter SHALL never wrap: a decrement at 0 is not permitted, and an unsigned width of counterwidth is sufficient.
REQ-025 txedge and collide SHALL default to 0 in every cycle in which they are not pulsed.

Reset
REQ-026 While reset_n=0, the block SHALL hold: driven=0, busy=0, pending=0, pendlevel=0, txedge=0, collide=0, counter=0, state IDLE.
REQ-027 Assertion of reset_n mid-HOLD or with pending set SHALL immediately force the REQ-026 values, discarding any pending request without emitting txedge.
REQ-028 After reset_n deasserts, the first rising edge SHALL process requests normally from IDLE.

Verification (holdtime=4)
REQ-029 Reset release, then risereq at edge 2 -> driven=1 and txedge=1 after edge 2; busy=1 for cycles 2-5; busy=0 after edge 6.
REQ-030 risereq at edge 2, fallreq at edge 3 -> pending=1 after edge 3; driven=0 and txedge=1 after edge 6; busy re-armed through edge 9.
REQ-031 risereq at edge 2, fallreq at edge 3, risereq at edge 4 -> pending cleared after edge 4; driven stays 1; IDLE after edge 6.
REQ-032 Idle driven=0 with risereq and fallreq both high at edge 2 -> collide=1 for one cycle; driven=0; busy=0; pending=0.
REQ-033 risereq at edge 2, fallreq at edge 3, reset_n low mid-cycle 4 -> all outputs 0 immediately; no txedge after release.
REQ-034 Random request streams of 10k cycles -> checker confirms REQ-022 spacing and that every txedge coincides with a change in driven.
